dco_ctrl: RTL and testbench



---
 rtl/dco_ctrl_if.sv | 47 ++++
 rtl/dco_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dco_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dco_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dco_ctrl_if
//  Description : Bundle between the loop filter (master) and the DCO tuning
//                controller (slave). The master supplies the enable and the
//                signed per-reference-cycle correction. The slave returns the
//                three capacitor-bank codes, the DCO enable and loop status.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    en          master->slave  loop enable
//    tune_valid  master->slave  tune_in valid this cycle
//    tune_in     master->slave  signed correction, LSBs of the active bank
//    dco_en      slave->master  DCO enable
//    dco_in_l    slave->master  coarse bank code
//    dco_in_m    slave->master  medium bank code
//    dco_in_s    slave->master  fine bank code
//    mode        slave->master  00 IDLE, 01 PVT, 10 ACQ, 11 TRK
//    locked      slave->master  fine tracking settled
// ============================================================================
interface dco_ctrl_if #(
    parameter int L_W  = 5,
    parameter int M_W  = 8,
    parameter int S_W  = 8,
    parameter int TW_W = 12
);
    logic                   en;
    logic                   tune_valid;
    logic signed [TW_W-1:0] tune_in;
    logic                   dco_en;
    logic [L_W-1:0]         dco_in_l;
    logic [M_W-1:0]         dco_in_m;
    logic [S_W-1:0]         dco_in_s;
    logic [1:0]             mode;
    logic                   locked;

    modport master (
        output en, tune_valid, tune_in,
        input  dco_en, dco_in_l, dco_in_m, dco_in_s, mode, locked
    );

    modport slave (
        input  en, tune_valid, tune_in,
        output dco_en, dco_in_l, dco_in_m, dco_in_s, mode, locked
    );
endinterface
`default_nettype wire

// File: rtl/dco_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dco_ctrl
//  Description : DCO tuning-word controller. Integrates the signed loop-filter
//                correction into the coarse (L), medium (M) and fine (S)
//                capacitor banks, stepping PVT -> ACQ -> TRK as the correction
//                settles, and flags lock while fine tracking is settled.
//                Everything runs on the reference clock; all outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   reference clock, rising edge
//    rst_n  in   asynchronous active-low reset
//    bus    slave modport of dco_ctrl_if (en/tune_valid/tune_in in;
//           dco_en/dco_in_l/dco_in_m/dco_in_s/mode/locked out)
// ============================================================================
module dco_ctrl #(
    parameter int L_W       = 5,
    parameter int M_W       = 8,
    parameter int S_W       = 8,
    parameter int TW_W      = 12,
    parameter int SETTLE_TH = 1,
    parameter int SETTLE_N  = 4,
    parameter int UNLOCK_TH = 8
) (
    input  wire        clk,
    input  wire        rst_n,
    dco_ctrl_if.slave  bus
);

    // Sum width: widest operand plus sign and one overflow bit, so that
    // bank + tune_in can never wrap.
    localparam int c_BW_MAX  = (L_W > M_W) ? ((L_W > S_W) ? L_W : S_W)
                                           : ((M_W > S_W) ? M_W : S_W);
    localparam int c_SUM_W   = ((TW_W > c_BW_MAX) ? TW_W : c_BW_MAX) + 2;
    localparam int c_CNT_W   = $clog2(SETTLE_N + 1);

    localparam logic [L_W-1:0] c_L_MID = L_W'(1 << (L_W - 1));
    localparam logic [M_W-1:0] c_M_MID = M_W'(1 << (M_W - 1));
    localparam logic [S_W-1:0] c_S_MID = S_W'(1 << (S_W - 1));

    localparam logic signed [c_SUM_W-1:0] c_L_MAX = c_SUM_W'((1 << L_W) - 1);
    localparam logic signed [c_SUM_W-1:0] c_M_MAX = c_SUM_W'((1 << M_W) - 1);
    localparam logic signed [c_SUM_W-1:0] c_S_MAX = c_SUM_W'((1 << S_W) - 1);

    localparam logic [c_SUM_W-1:0] c_SETTLE_TH = c_SUM_W'(SETTLE_TH);
    localparam logic [c_SUM_W-1:0] c_UNLOCK_TH = c_SUM_W'(UNLOCK_TH);
    localparam logic [c_CNT_W-1:0] c_SETTLE_N  = c_CNT_W'(SETTLE_N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PVT  = 2'b01,
        ST_ACQ  = 2'b10,
        ST_TRK  = 2'b11
    } state_t;

    state_t             r_state;
    logic               r_dco_en;
    logic               r_locked;
    logic [L_W-1:0]     r_l;
    logic [M_W-1:0]     r_m;
    logic [S_W-1:0]     r_s;
    logic [c_CNT_W-1:0] r_cnt;

    logic signed [c_SUM_W-1:0] w_tune;
    logic        [c_SUM_W-1:0] w_abs;
    logic signed [c_SUM_W-1:0] w_base;
    logic signed [c_SUM_W-1:0] w_max;
    logic signed [c_SUM_W-1:0] w_sum;
    logic                      w_under;
    logic                      w_over;
    logic                      w_settled;
    logic                      w_unlock;
    logic [c_CNT_W-1:0]        w_cnt_inc;
    logic [L_W-1:0]            w_new_l;
    logic [M_W-1:0]            w_new_m;
    logic [S_W-1:0]            w_new_s;

    // Magnitude taken at the wide sum width so the most negative tune word
    // still has a representable absolute value.
    assign w_tune    = c_SUM_W'(bus.tune_in);
    assign w_abs     = w_tune[c_SUM_W-1] ? c_SUM_W'(-w_tune) : c_SUM_W'(w_tune);
    assign w_settled = (w_abs <= c_SETTLE_TH);
    assign w_unlock  = (w_abs >  c_UNLOCK_TH);
    assign w_cnt_inc = r_cnt + 1'b1;

    // Active bank selection: PVT drives L, ACQ drives M, TRK drives S.
    always_comb begin
        w_base = '0;
        w_max  = c_S_MAX;
        case (r_state)
            ST_PVT: begin
                w_base = $signed({{(c_SUM_W-L_W){1'b0}}, r_l});
                w_max  = c_L_MAX;
            end
            ST_ACQ: begin
                w_base = $signed({{(c_SUM_W-M_W){1'b0}}, r_m});
                w_max  = c_M_MAX;
            end
            default: begin
                w_base = $signed({{(c_SUM_W-S_W){1'b0}}, r_s});
                w_max  = c_S_MAX;
            end
        endcase
    end

    assign w_sum   = w_base + w_tune;
    assign w_under = w_sum[c_SUM_W-1];
    assign w_over  = (w_sum > w_max);

    assign w_new_l = w_under ? '0 : (w_over ? '1 : w_sum[L_W-1:0]);
    assign w_new_m = w_under ? '0 : (w_over ? '1 : w_sum[M_W-1:0]);
    assign w_new_s = w_under ? '0 : (w_over ? '1 : w_sum[S_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dco_en <= 1'b0;
            r_locked <= 1'b0;
            r_l      <= c_L_MID;
            r_m      <= c_M_MID;
            r_s      <= c_S_MID;
            r_cnt    <= '0;
        end else if (!bus.en) begin
            r_state  <= ST_IDLE;
            r_dco_en <= 1'b0;
            r_locked <= 1'b0;
            r_l      <= c_L_MID;
            r_m      <= c_M_MID;
            r_s      <= c_S_MID;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_PVT;
                    r_dco_en <= 1'b1;
                end

                ST_PVT, ST_ACQ: begin
                    if (bus.tune_valid) begin
                        // The completing sample still lands in the old bank.
                        if (r_state == ST_PVT) r_l <= w_new_l;
                        else                   r_m <= w_new_m;
                        if (w_settled) begin
                            if (w_cnt_inc == c_SETTLE_N) begin
                                r_cnt   <= '0;
                                r_state <= (r_state == ST_PVT) ? ST_ACQ : ST_TRK;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end

                default: begin // ST_TRK
                    if (bus.tune_valid) begin
                        // Fine-bank excursions past a rail recentre S and
                        // push the step into M, unless M is already railed.
                        if (w_over && (r_m != '1)) begin
                            r_s <= c_S_MID;
                            r_m <= r_m + 1'b1;
                        end else if (w_under && (r_m != '0)) begin
                            r_s <= c_S_MID;
                            r_m <= r_m - 1'b1;
                        end else begin
                            r_s <= w_new_s;
                        end

                        if (w_unlock) begin
                            r_locked <= 1'b0;
                            r_cnt    <= '0;
                        end else if (w_settled) begin
                            if (w_cnt_inc >= c_SETTLE_N) begin
                                r_cnt    <= c_SETTLE_N;
                                r_locked <= 1'b1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.dco_en   = r_dco_en;
    assign bus.dco_in_l = r_l;
    assign bus.dco_in_m = r_m;
    assign bus.dco_in_s = r_s;
    assign bus.mode     = r_state;
    assign bus.locked   = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_dco_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dco_ctrl
//  Description : Directed self-checking bench for dco_ctrl. Inputs change on
//                the falling edge, outputs are checked on the following
//                falling edge (one rising edge later).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dco_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    dco_ctrl_if bus ();

    dco_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one input vector across one rising edge, return at the next
    // falling edge where outputs are stable.
    task automatic step(input logic valid, input int tune);
        bus.tune_valid = valid;
        bus.tune_in    = 12'(tune);
        @(posedge clk);
        @(negedge clk);
        bus.tune_valid = 1'b0;
        bus.tune_in    = '0;
    endtask

    task automatic check_all(input string tag, input int md, input int de,
                             input int l, input int m, input int s, input int lk);
        check({tag, "_mode"}, 32'(bus.mode), 32'(md));
        check({tag, "_dco_en"}, 32'(bus.dco_en), 32'(de));
        check({tag, "_l"}, 32'(bus.dco_in_l), 32'(l));
        check({tag, "_m"}, 32'(bus.dco_in_m), 32'(m));
        check({tag, "_s"}, 32'(bus.dco_in_s), 32'(s));
        check({tag, "_locked"}, 32'(bus.locked), 32'(lk));
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.tune_valid = 1'b0;
        bus.tune_in    = '0;

        // Reset and IDLE
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 16, 128, 128, 0);
        rst_n = 1'b1;
        step(1'b1, 7);                       // en=0: input ignored
        check_all("idle", 0, 0, 16, 128, 128, 0);

        // Enter PVT
        bus.en = 1'b1;
        step(1'b0, 0);
        check_all("pvt_entry", 1, 1, 16, 128, 128, 0);

        // PVT update and clamping
        step(1'b1, 5);
        check("pvt_plus5", 32'(bus.dco_in_l), 32'd21);
        step(1'b1, 20);
        check("pvt_clamp_hi", 32'(bus.dco_in_l), 32'd31);
        step(1'b1, -40);
        check("pvt_clamp_lo", 32'(bus.dco_in_l), 32'd0);

        // Settle progression with gaps and a restart
        step(1'b1, 0);
        step(1'b0, 0);
        step(1'b1, 0);
        step(1'b1, 3);                       // restarts count, l = 3
        check_all("pvt_restart", 1, 1, 3, 128, 128, 0);
        step(1'b1, 1);                       // l = 4
        step(1'b0, 0);
        step(1'b1, -1);                      // l = 3
        step(1'b1, 0);
        check("pvt_3rd_settled_mode", 32'(bus.mode), 32'd1);
        step(1'b1, 0);
        check_all("acq_entry", 2, 1, 3, 128, 128, 0);

        // ACQ
        step(1'b1, -28);
        check("acq_m", 32'(bus.dco_in_m), 32'd100);
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b1, 0);
        check("acq_3rd_mode", 32'(bus.mode), 32'd2);
        step(1'b1, 0);
        check_all("trk_entry", 3, 1, 3, 100, 128, 0);

        // Lock in TRK
        step(1'b1, 1);
        step(1'b1, -1);
        step(1'b1, 1);
        check("trk_3rd_unlocked", 32'(bus.locked), 32'd0);
        step(1'b1, -1);
        check_all("trk_locked", 3, 1, 3, 100, 128, 1);
        step(1'b1, 0);
        check("trk_locked_hold", 32'(bus.locked), 32'd1);
        step(1'b1, 9);
        check_all("trk_unlock", 3, 1, 3, 100, 137, 0);

        // Carry and borrow
        step(1'b1, 113);
        check("trk_s250", 32'(bus.dco_in_s), 32'd250);
        step(1'b1, 10);
        check("carry_s", 32'(bus.dco_in_s), 32'd128);
        check("carry_m", 32'(bus.dco_in_m), 32'd101);
        step(1'b1, -125);
        check("trk_s3", 32'(bus.dco_in_s), 32'd3);
        step(1'b1, -5);
        check("borrow_s", 32'(bus.dco_in_s), 32'd128);
        check("borrow_m", 32'(bus.dco_in_m), 32'd100);

        // Disable mid-operation
        bus.en = 1'b0;
        step(1'b1, 4);
        check_all("disable", 0, 0, 16, 128, 128, 0);

        // Drive M to its top rail, then try a blocked carry
        bus.en = 1'b1;
        step(1'b0, 0);
        repeat (4) step(1'b1, 0);
        check("re_acq_mode", 32'(bus.mode), 32'd2);
        step(1'b1, 200);
        check("acq_clamp_m", 32'(bus.dco_in_m), 32'd255);
        repeat (4) step(1'b1, 0);
        check("re_trk_mode", 32'(bus.mode), 32'd3);
        step(1'b1, 122);
        check("trk_s250b", 32'(bus.dco_in_s), 32'd250);
        step(1'b1, 10);
        check_all("carry_blocked", 3, 1, 16, 255, 255, 0);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 16, 128, 128, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
